// File: rtl/rbus_ring_stop.sv
// rbus ring stop: per-channel injection FIFOs feeding the ring with transit priority,
// round-robin fairness and a starvation guard; ejects local traffic, removes returned packets.
module rbus_ring_stop #(
  parameter int NCH        = 2,
  parameter int DW         = 549,
  parameter int IDW        = 10,
  parameter int DEPTH      = 4,
  parameter int ID_BASE    = 0,
  parameter int STARVE_LIM = 15,
  localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       inj_valid,
  output logic [NCH-1:0]       inj_ready,
  input  logic [NCH*IDW-1:0]   inj_dst,
  input  logic [NCH*DW-1:0]    inj_data,
  input  logic                 ring_in_valid,
  output logic                 ring_in_ready,
  input  logic [IDW-1:0]       ring_in_src,
  input  logic [IDW-1:0]       ring_in_dst,
  input  logic [DW-1:0]        ring_in_data,
  output logic                 ring_out_valid,
  input  logic                 ring_out_ready,
  output logic [IDW-1:0]       ring_out_src,
  output logic [IDW-1:0]       ring_out_dst,
  output logic [DW-1:0]        ring_out_data,
  input  logic                 ej_ready,
  output logic                 ej_valid,
  output logic [CW-1:0]        ej_chan,
  output logic [IDW-1:0]       ej_src,
  output logic [DW-1:0]        ej_data,
  output logic                 drop_valid,
  output logic [CW-1:0]        drop_chan
);

  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int PTRW = $clog2(DEPTH);
  localparam int SW   = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
  localparam int IDW1 = IDW + 1;

  localparam logic [CNTW-1:0] FULL_CNT   = CNTW'(DEPTH);
  localparam logic [PTRW-1:0] LAST_PTR   = PTRW'(DEPTH - 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIM);
  localparam logic [IDW-1:0]  BASE_ID    = IDW'(ID_BASE);
  localparam logic [IDW:0]    LO_ID      = IDW1'(ID_BASE);
  localparam logic [IDW:0]    NCH_ID     = IDW1'(NCH);
  localparam logic [CW-1:0]   LAST_CH    = CW'(NCH - 1);

  logic                slotFree, hold, accept;
  logic                dstLocal, srcLocal;
  logic                takeEject, takeDrop, takeFwd;
  logic                anyNonEmpty, grant;
  logic [NCH-1:0]      nonEmpty, push, pop;
  logic [CW-1:0]       winner, rrPtr;
  logic [SW-1:0]       starveCnt;
  logic [IDW-1:0]      headDst;
  logic [DW-1:0]       headData;

  logic [CNTW-1:0]     count   [NCH];
  logic [PTRW-1:0]     rdPtr   [NCH];
  logic [PTRW-1:0]     wrPtr   [NCH];
  logic [IDW-1:0]      memDst  [NCH][DEPTH];
  logic [DW-1:0]       memData [NCH][DEPTH];

  // Owned-ID test done as a borrow-checked subtraction so it never wraps.
  function automatic logic isLocal(input logic [IDW-1:0] id);
    logic [IDW+1:0] diff;
    diff = {2'b00, id} - {1'b0, LO_ID};
    return !diff[IDW+1] && (diff[IDW:0] < NCH_ID);
  endfunction

  always_comb begin
    nonEmpty  = '0;
    inj_ready = '0;
    push      = '0;
    for (int c = 0; c < NCH; c++) begin
      nonEmpty[c]  = (count[c] != '0);
      inj_ready[c] = (count[c] < FULL_CNT) && !rst;
      push[c]      = inj_valid[c] && inj_ready[c];
    end
  end

  always_comb begin
    slotFree      = !ring_out_valid || ring_out_ready;
    hold          = (starveCnt == STARVE_MAX);
    ring_in_ready = slotFree && !hold && !rst;
    accept        = ring_in_valid && ring_in_ready;
    dstLocal      = isLocal(ring_in_dst);
    srcLocal      = isLocal(ring_in_src);
    takeEject     = accept && dstLocal && ej_ready;
    takeDrop      = accept && !takeEject && srcLocal;
    takeFwd       = accept && !takeEject && !takeDrop;
    anyNonEmpty   = |nonEmpty;
    grant         = slotFree && !takeFwd && anyNonEmpty && !rst;
  end

  // Lowest non-empty channel overall, overridden by the lowest one at or above rrPtr.
  always_comb begin
    winner = rrPtr;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (nonEmpty[c]) winner = CW'(c);
    end
    for (int c = NCH - 1; c >= 0; c--) begin
      if (nonEmpty[c] && (CW'(c) >= rrPtr)) winner = CW'(c);
    end
  end

  always_comb begin
    pop = '0;
    for (int c = 0; c < NCH; c++) begin
      pop[c] = grant && (winner == CW'(c));
    end
  end

  assign headDst  = memDst[winner][rdPtr[winner]];
  assign headData = memData[winner][rdPtr[winner]];

  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (push[c]) begin
        memDst[c][wrPtr[c]]  <= inj_dst[c*IDW +: IDW];
        memData[c][wrPtr[c]] <= inj_data[c*DW +: DW];
      end
    end
  end

  // A full FIFO never accepts a push, even in a cycle where it is popped.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (rst) begin
        count[c] <= '0;
        rdPtr[c] <= '0;
        wrPtr[c] <= '0;
      end else begin
        if (push[c]) wrPtr[c] <= (wrPtr[c] == LAST_PTR) ? '0 : wrPtr[c] + PTRW'(1);
        if (pop[c])  rdPtr[c] <= (rdPtr[c] == LAST_PTR) ? '0 : rdPtr[c] + PTRW'(1);
        if (push[c] && !pop[c])      count[c] <= count[c] + CNTW'(1);
        else if (!push[c] && pop[c]) count[c] <= count[c] - CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ring_out_valid <= 1'b0;
    end else if (takeFwd) begin
      ring_out_valid <= 1'b1;
      ring_out_src   <= ring_in_src;
      ring_out_dst   <= ring_in_dst;
      ring_out_data  <= ring_in_data;
    end else if (grant) begin
      ring_out_valid <= 1'b1;
      ring_out_src   <= BASE_ID + IDW'(winner);
      ring_out_dst   <= headDst;
      ring_out_data  <= headData;
    end else if (ring_out_ready) begin
      ring_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    ej_valid   <= !rst && takeEject;
    drop_valid <= !rst && takeDrop;
    if (takeEject) begin
      ej_chan <= CW'(ring_in_dst - BASE_ID);
      ej_src  <= ring_in_src;
      ej_data <= ring_in_data;
    end
    if (takeDrop) drop_chan <= CW'(ring_in_src - BASE_ID);
  end

  // The starve counter sits at its limit until a grant actually lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr     <= '0;
      starveCnt <= '0;
    end else begin
      if (grant) rrPtr <= (winner == LAST_CH) ? '0 : winner + CW'(1);
      if (grant || !anyNonEmpty)     starveCnt <= '0;
      else if (starveCnt != STARVE_MAX) starveCnt <= starveCnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_rbus_ring_stop.sv
// Self-checking bench for rbus_ring_stop: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model of the stop.
module tb_rbus_ring_stop;

  localparam int NCH = 2, DW = 16, IDW = 10, DEPTH = 4, ID_BASE = 4, STARVE_LIM = 15, CW = 1;

  logic               clk = 1'b0;
  logic               rst;
  logic [NCH-1:0]     injValid, injReady;
  logic [NCH*IDW-1:0] injDst;
  logic [NCH*DW-1:0]  injData;
  logic               ringInValid, ringInReady;
  logic [IDW-1:0]     ringInSrc, ringInDst;
  logic [DW-1:0]      ringInData;
  logic               ringOutValid, ringOutReady;
  logic [IDW-1:0]     ringOutSrc, ringOutDst;
  logic [DW-1:0]      ringOutData;
  logic               ejReady, ejValid;
  logic [CW-1:0]      ejChan;
  logic [IDW-1:0]     ejSrc;
  logic [DW-1:0]      ejData;
  logic               dropValid;
  logic [CW-1:0]      dropChan;

  int checks = 0;
  int fails  = 0;

  // Behavioural model state
  logic [IDW+DW-1:0] mq [NCH][$];
  bit             mOutV, mEjV, mDropV;
  logic [IDW-1:0] mOutSrc, mOutDst, mEjSrc;
  logic [DW-1:0]  mOutData, mEjData;
  logic [CW-1:0]  mEjChan, mDropChan;
  int             mRr, mStarve;

  rbus_ring_stop #(.NCH(NCH), .DW(DW), .IDW(IDW), .DEPTH(DEPTH), .ID_BASE(ID_BASE),
                   .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .rst(rst),
    .inj_valid(injValid), .inj_ready(injReady), .inj_dst(injDst), .inj_data(injData),
    .ring_in_valid(ringInValid), .ring_in_ready(ringInReady), .ring_in_src(ringInSrc),
    .ring_in_dst(ringInDst), .ring_in_data(ringInData),
    .ring_out_valid(ringOutValid), .ring_out_ready(ringOutReady), .ring_out_src(ringOutSrc),
    .ring_out_dst(ringOutDst), .ring_out_data(ringOutData),
    .ej_ready(ejReady), .ej_valid(ejValid), .ej_chan(ejChan), .ej_src(ejSrc), .ej_data(ejData),
    .drop_valid(dropValid), .drop_chan(dropChan)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic setIdle();
    injValid = '0; injDst = '0; injData = '0;
    ringInValid = 1'b0; ringInSrc = '0; ringInDst = '0; ringInData = '0;
    ringOutReady = 1'b1; ejReady = 1'b1;
  endtask

  task automatic resetDut();
    @(negedge clk);
    setIdle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pushChan(input int c, input logic [IDW-1:0] d, input logic [DW-1:0] x);
    injValid[c] = 1'b1;
    injDst[c*IDW +: IDW] = d;
    injData[c*DW +: DW] = x;
  endtask

  function automatic bit isOwn(input logic [IDW-1:0] id);
    return (int'(id) >= ID_BASE) && (int'(id) < ID_BASE + NCH);
  endfunction

  function automatic logic [IDW-1:0] pickId();
    case ($urandom_range(0, 5))
      0: return IDW'(3);
      1: return IDW'(4);
      2: return IDW'(5);
      3: return IDW'(6);
      4: return IDW'(20);
      default: return IDW'($urandom_range(0, 1023));
    endcase
  endfunction

  task automatic modelReset();
    for (int c = 0; c < NCH; c++) mq[c].delete();
    mOutV = 0; mEjV = 0; mDropV = 0; mRr = 0; mStarve = 0;
  endtask

  // One clock of the stop's rules, applied to the inputs currently driven.
  task automatic modelStep();
    bit slotFree, accept, ej, dr, fw, grant;
    bit [NCH-1:0] canPush;
    int win;
    logic [IDW+DW-1:0] head;
    if (rst) begin
      modelReset();
      return;
    end
    slotFree = !mOutV || ringOutReady;
    accept   = ringInValid && slotFree && (mStarve != STARVE_LIM);
    ej       = accept && isOwn(ringInDst) && ejReady;
    dr       = accept && !ej && isOwn(ringInSrc);
    fw       = accept && !ej && !dr;
    win = -1;
    for (int i = 0; i < NCH; i++) begin
      if (win < 0 && mq[(mRr + i) % NCH].size() > 0) win = (mRr + i) % NCH;
    end
    grant = slotFree && !fw && (win >= 0);
    for (int c = 0; c < NCH; c++) canPush[c] = injValid[c] && (mq[c].size() < DEPTH);
    mEjV = ej;
    if (ej) begin
      mEjChan = CW'(int'(ringInDst) - ID_BASE);
      mEjSrc = ringInSrc;
      mEjData = ringInData;
    end
    mDropV = dr;
    if (dr) mDropChan = CW'(int'(ringInSrc) - ID_BASE);
    if (fw) begin
      mOutV = 1; mOutSrc = ringInSrc; mOutDst = ringInDst; mOutData = ringInData;
    end else if (grant) begin
      head = mq[win].pop_front();
      mOutV = 1; mOutSrc = IDW'(ID_BASE + win); {mOutDst, mOutData} = head;
      mRr = (win + 1) % NCH;
    end else if (ringOutReady) begin
      mOutV = 0;
    end
    if (grant || win < 0) mStarve = 0;
    else if (mStarve < STARVE_LIM) mStarve++;
    for (int c = 0; c < NCH; c++)
      if (canPush[c]) mq[c].push_back({injDst[c*IDW +: IDW], injData[c*DW +: DW]});
  endtask

  task automatic test_reset();
    @(negedge clk);
    setIdle();
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({ringOutValid, ejValid, dropValid} !== 3'b000) begin
      fails++; $display("[TB] FAIL reset_valids: got %b required 000", {ringOutValid, ejValid, dropValid});
    end
    checks++;
    if ({injReady, ringInReady} !== 3'b000) begin
      fails++; $display("[TB] FAIL reset_readies: got %b required 000", {injReady, ringInReady});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({injReady, ringInReady} !== 3'b111) begin
      fails++; $display("[TB] FAIL post_reset_readies: got %b required 111", {injReady, ringInReady});
    end
  endtask

  task automatic test_inject();
    resetDut();
    pushChan(1, 10'd9, 16'hA5);
    @(negedge clk);
    injValid = '0;
    #1;
    checks++;
    if ({ringOutValid, injReady} !== 3'b011) begin
      fails++; $display("[TB] FAIL inject_edge1: got %b required 011", {ringOutValid, injReady});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({ringOutValid, ringOutSrc, ringOutDst, ringOutData, injReady} !== {1'b1, 10'd5, 10'd9, 16'hA5, 2'b11}) begin
      fails++; $display("[TB] FAIL inject_out: got v=%b src=%0d dst=%0d data=%h rdy=%b required 1/5/9/a5/11",
                        ringOutValid, ringOutSrc, ringOutDst, ringOutData, injReady);
    end
    @(negedge clk);
    #1;
    checks++;
    if (ringOutValid !== 1'b0) begin
      fails++; $display("[TB] FAIL inject_one_cycle: got %b required 0", ringOutValid);
    end
  endtask

  task automatic test_eject();
    resetDut();
    ringInValid = 1'b1; ringInSrc = 10'd20; ringInDst = 10'd4; ringInData = 16'h1234; ejReady = 1'b1;
    @(negedge clk);
    ringInValid = 1'b0;
    #1;
    checks++;
    if ({ejValid, ejChan, ejSrc, ejData, ringOutValid, dropValid} !== {1'b1, 1'b0, 10'd20, 16'h1234, 1'b0, 1'b0}) begin
      fails++; $display("[TB] FAIL eject: got ej=%b ch=%0d src=%0d data=%h out=%b drop=%b required 1/0/20/1234/0/0",
                        ejValid, ejChan, ejSrc, ejData, ringOutValid, dropValid);
    end
    ejReady = 1'b0;
    ringInValid = 1'b1; ringInData = 16'h5678;
    @(negedge clk);
    ringInValid = 1'b0; ejReady = 1'b1;
    #1;
    checks++;
    if ({ejValid, ringOutValid, ringOutSrc, ringOutDst, ringOutData} !== {1'b0, 1'b1, 10'd20, 10'd4, 16'h5678}) begin
      fails++; $display("[TB] FAIL eject_blocked_fwd: got ej=%b v=%b src=%0d dst=%0d data=%h required 0/1/20/4/5678",
                        ejValid, ringOutValid, ringOutSrc, ringOutDst, ringOutData);
    end
  endtask

  task automatic test_drop_reuse();
    resetDut();
    pushChan(0, 10'd7, 16'h33);
    @(negedge clk);
    injValid = '0;
    ringInValid = 1'b1; ringInSrc = 10'd5; ringInDst = 10'd30; ringInData = 16'hDEAD;
    #1;
    checks++;
    if (ringInReady !== 1'b1) begin
      fails++; $display("[TB] FAIL drop_ring_in_ready: got %b required 1", ringInReady);
    end
    @(negedge clk);
    ringInValid = 1'b0;
    #1;
    checks++;
    if ({dropValid, dropChan, ejValid, ringOutValid, ringOutSrc, ringOutDst, ringOutData} !==
        {1'b1, 1'b1, 1'b0, 1'b1, 10'd4, 10'd7, 16'h33}) begin
      fails++; $display("[TB] FAIL drop_reuse: got drop=%b ch=%0d ej=%b v=%b src=%0d dst=%0d data=%h required 1/1/0/1/4/7/33",
                        dropValid, dropChan, ejValid, ringOutValid, ringOutSrc, ringOutDst, ringOutData);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({dropValid, ringOutValid} !== 2'b00) begin
      fails++; $display("[TB] FAIL drop_one_cycle: got %b required 00", {dropValid, ringOutValid});
    end
  endtask

  task automatic test_round_robin();
    logic [IDW-1:0] gotSrc [$];
    logic [DW-1:0]  gotData [$];
    resetDut();
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc < 3) begin
        pushChan(0, IDW'(10 + cyc), DW'(16'h100 + cyc));
        pushChan(1, IDW'(20 + cyc), DW'(16'h200 + cyc));
      end else begin
        injValid = '0;
      end
      #1;
      if (ringOutValid) begin
        gotSrc.push_back(ringOutSrc);
        gotData.push_back(ringOutData);
      end
      @(negedge clk);
    end
    checks++;
    if (gotSrc.size() != 6) begin
      fails++; $display("[TB] FAIL rr_count: got %0d packets required 6", gotSrc.size());
    end
    for (int i = 0; i < 6 && i < gotSrc.size(); i++) begin
      checks++;
      if ({gotSrc[i], gotData[i]} !== {IDW'(ID_BASE + i % 2), DW'(((i % 2) ? 16'h200 : 16'h100) + i / 2)}) begin
        fails++; $display("[TB] FAIL rr_order[%0d]: got src=%0d data=%h required src=%0d data=%h", i, gotSrc[i], gotData[i],
                          ID_BASE + i % 2, ((i % 2) ? 16'h200 : 16'h100) + i / 2);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] gotData [$];
    resetDut();
    ringOutReady = 1'b0;
    ringInValid = 1'b1; ringInSrc = 10'd20; ringInDst = 10'd30; ringInData = 16'hBEEF;
    @(negedge clk);
    ringInValid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (injReady[0] !== 1'b1) begin
        fails++; $display("[TB] FAIL bp_ready_before_full[%0d]: got %b required 1", k, injReady[0]);
      end
      pushChan(0, 10'd40, DW'(k + 1));
      @(negedge clk);
    end
    pushChan(0, 10'd40, 16'hEE);
    #1;
    checks++;
    if (injReady !== 2'b10) begin
      fails++; $display("[TB] FAIL bp_full: got %b required 10", injReady);
    end
    @(negedge clk);
    ringOutReady = 1'b1;
    #1;
    checks++;
    if (injReady[0] !== 1'b0) begin
      fails++; $display("[TB] FAIL bp_full_during_pop: got %b required 0", injReady[0]);
    end
    @(negedge clk);
    #1;
    checks++;
    if (injReady[0] !== 1'b1) begin
      fails++; $display("[TB] FAIL bp_ready_after_pop: got %b required 1", injReady[0]);
    end
    injValid = '0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      if (ringOutValid) gotData.push_back(ringOutData);
      @(negedge clk);
    end
    checks++;
    if (gotData.size() != 4) begin
      fails++; $display("[TB] FAIL bp_drain_count: got %0d required 4", gotData.size());
    end
    for (int i = 0; i < 4 && i < gotData.size(); i++) begin
      checks++;
      if (gotData[i] !== DW'(i + 1)) begin
        fails++; $display("[TB] FAIL bp_drain[%0d]: got %h required %h", i, gotData[i], i + 1);
      end
    end
  endtask

  task automatic test_starvation();
    int waitCycles;
    bit sawHold;
    waitCycles = 0;
    sawHold = 0;
    resetDut();
    ringInValid = 1'b1; ringInSrc = 10'd20; ringInDst = 10'd30; ringInData = 16'h0F0F;
    @(negedge clk);
    pushChan(0, 10'd50, 16'h77);
    @(negedge clk);
    injValid = '0;
    for (int cyc = 0; cyc < 40 && !sawHold; cyc++) begin
      #1;
      if (ringInReady) begin
        waitCycles++;
        @(negedge clk);
      end else begin
        sawHold = 1;
      end
    end
    checks++;
    if (!sawHold || waitCycles != STARVE_LIM) begin
      fails++; $display("[TB] FAIL starve_hold: got hold=%0d after %0d cycles required hold after %0d", sawHold, waitCycles, STARVE_LIM);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({ringOutValid, ringOutSrc, ringOutDst, ringOutData, ringInReady} !== {1'b1, 10'd4, 10'd50, 16'h77, 1'b1}) begin
      fails++; $display("[TB] FAIL starve_inject: got v=%b src=%0d dst=%0d data=%h rir=%b required 1/4/50/77/1",
                        ringOutValid, ringOutSrc, ringOutDst, ringOutData, ringInReady);
    end
    ringInValid = 1'b0;
  endtask

  task automatic test_mid_reset();
    int leftovers;
    leftovers = 0;
    resetDut();
    pushChan(0, 10'd60, 16'h61);
    @(negedge clk);
    injValid = '0;
    ringOutReady = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      pushChan(0, IDW'(61 + k), DW'(16'h62 + k));
      pushChan(1, IDW'(63 + k), DW'(16'h64 + k));
      @(negedge clk);
    end
    injValid = '0;
    rst = 1'b1;
    #1;
    checks++;
    if ({injReady, ringInReady} !== 3'b000) begin
      fails++; $display("[TB] FAIL mid_rst_readies: got %b required 000", {injReady, ringInReady});
    end
    @(negedge clk);
    rst = 1'b0;
    ringOutReady = 1'b1;
    #1;
    checks++;
    if ({ringOutValid, injReady, ringInReady} !== 4'b0111) begin
      fails++; $display("[TB] FAIL mid_rst_after: got %b required 0111", {ringOutValid, injReady, ringInReady});
    end
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      #1;
      if (ringOutValid) leftovers++;
    end
    checks++;
    if (leftovers != 0) begin
      fails++; $display("[TB] FAIL mid_rst_fifo_empty: got %0d stale packets required 0", leftovers);
    end
    pushChan(0, 10'd70, 16'h70);
    pushChan(1, 10'd71, 16'h71);
    @(negedge clk);
    injValid = '0;
    @(negedge clk);
    #1;
    checks++;
    if ({ringOutValid, ringOutSrc, ringOutData} !== {1'b1, 10'd4, 16'h70}) begin
      fails++; $display("[TB] FAIL mid_rst_rr_first: got v=%b src=%0d data=%h required 1/4/70", ringOutValid, ringOutSrc, ringOutData);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({ringOutValid, ringOutSrc, ringOutData} !== {1'b1, 10'd5, 16'h71}) begin
      fails++; $display("[TB] FAIL mid_rst_rr_second: got v=%b src=%0d data=%h required 1/5/71", ringOutValid, ringOutSrc, ringOutData);
    end
  endtask

  task automatic test_random();
    bit [NCH-1:0] expInj;
    bit expRir;
    resetDut();
    modelReset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int c = 0; c < NCH; c++) begin
        injValid[c] = ($urandom_range(0, 2) == 0);
        injDst[c*IDW +: IDW] = pickId();
        injData[c*DW +: DW] = DW'($urandom);
      end
      ringInValid = ($urandom_range(0, 1) == 1);
      ringInSrc = pickId();
      ringInDst = pickId();
      ringInData = DW'($urandom);
      ringOutReady = ($urandom_range(0, 3) != 0);
      ejReady = ($urandom_range(0, 3) != 0);
      #1;
      for (int c = 0; c < NCH; c++) expInj[c] = !rst && (mq[c].size() < DEPTH);
      expRir = !rst && (!mOutV || ringOutReady) && (mStarve != STARVE_LIM);
      checks++;
      if ({ringInReady, injReady} !== {expRir, expInj}) begin
        fails++; $display("[TB] FAIL rand_ready cyc %0d: got %b required %b", cyc, {ringInReady, injReady}, {expRir, expInj});
      end
      checks++;
      if (ringOutValid !== mOutV || (mOutV && {ringOutSrc, ringOutDst, ringOutData} !== {mOutSrc, mOutDst, mOutData})) begin
        fails++; $display("[TB] FAIL rand_ring_out cyc %0d: got v=%b %0d/%0d/%h required v=%b %0d/%0d/%h", cyc,
                          ringOutValid, ringOutSrc, ringOutDst, ringOutData, mOutV, mOutSrc, mOutDst, mOutData);
      end
      checks++;
      if (ejValid !== mEjV || (mEjV && {ejChan, ejSrc, ejData} !== {mEjChan, mEjSrc, mEjData})) begin
        fails++; $display("[TB] FAIL rand_eject cyc %0d: got v=%b %0d/%0d/%h required v=%b %0d/%0d/%h", cyc,
                          ejValid, ejChan, ejSrc, ejData, mEjV, mEjChan, mEjSrc, mEjData);
      end
      checks++;
      if (dropValid !== mDropV || (mDropV && dropChan !== mDropChan)) begin
        fails++; $display("[TB] FAIL rand_drop cyc %0d: got v=%b ch=%0d required v=%b ch=%0d", cyc,
                          dropValid, dropChan, mDropV, mDropChan);
      end
      modelStep();
      @(negedge clk);
    end
    rst = 1'b0;
    setIdle();
  endtask

  initial begin
    setIdle();
    rst = 1'b1;
    test_reset();
    test_inject();
    test_eject();
    test_drop_reuse();
    test_round_robin();
    test_backpressure();
    test_starvation();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
